// File: rtl/exception_unit.sv
// Commit-stage exception arbiter feeding the CP0 exception-update port and the fetch redirect.
// Optional trap support (exc_vec[11] -> Tr) is compiled in with EXCEPTION_TRAP_EN.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter logic [31:0] REFILL_VECTOR = 32'hBFC00200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic [31:0] commit_mem_addr,
    input  logic [11:0] exc_vec,
    input  logic        tlb_refill,
    input  logic        eret,
    input  logic        allow_interrupt,
    input  logic [7:0]  interrupt_flag,
    input  logic [31:0] epc_address,
    input  logic        cp0_cause_bd,
    input  logic [4:0]  cp0_cause_exccode,
    output logic        exp_en,
    output logic        exp_badvaddr_en,
    output logic        exp_bd,
    output logic        exl_clean,
    output logic [4:0]  exp_code,
    output logic [31:0] exp_epc,
    output logic [31:0] exp_badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_exp_en, r_bad_en, r_bd, r_exl_clean, r_flush, r_rvalid, r_busy;
    logic [4:0]  r_code;
    logic [31:0] r_epc, r_badvaddr, r_rpc;

    logic        w_exp_en_nxt, w_bad_en_nxt, w_bd_nxt, w_exl_clean_nxt, w_flush_nxt, w_rvalid_nxt;
    logic [4:0]  w_code_nxt;
    logic [31:0] w_epc_nxt, w_badvaddr_nxt, w_rpc_nxt;

    logic        w_int, w_tr, w_hit, w_eret, w_tlb, w_bad_en;
    logic [4:0]  w_code;
    logic [31:0] w_bad;

    assign w_int = allow_interrupt && (|interrupt_flag);

`ifdef EXCEPTION_TRAP_EN
    assign w_tr = exc_vec[11];
`else
    logic w_unused_tr;
    assign w_unused_tr = exc_vec[11];
    assign w_tr        = 1'b0;
`endif

    // Priority select: only the highest pending event is recorded
    always_comb begin
        w_hit    = 1'b1;
        w_eret   = 1'b0;
        w_tlb    = 1'b0;
        w_bad_en = 1'b0;
        w_bad    = commit_mem_addr;
        w_code   = 5'd0;
        if (w_int)            begin w_code = 5'd0; end
        else if (exc_vec[0])  begin w_code = 5'd4;  w_bad_en = 1'b1; w_bad = commit_pc; end
        else if (exc_vec[1])  begin w_code = 5'd2;  w_bad_en = 1'b1; w_bad = commit_pc; w_tlb = 1'b1; end
        else if (exc_vec[2])  begin w_code = 5'd10; end
        else if (exc_vec[3])  begin w_code = 5'd8;  end
        else if (exc_vec[4])  begin w_code = 5'd9;  end
        else if (w_tr)        begin w_code = 5'd13; end
        else if (exc_vec[5])  begin w_code = 5'd12; end
        else if (exc_vec[6])  begin w_code = 5'd4;  w_bad_en = 1'b1; end
        else if (exc_vec[7])  begin w_code = 5'd5;  w_bad_en = 1'b1; end
        else if (exc_vec[8])  begin w_code = 5'd2;  w_bad_en = 1'b1; w_tlb = 1'b1; end
        else if (exc_vec[9])  begin w_code = 5'd3;  w_bad_en = 1'b1; w_tlb = 1'b1; end
        else if (exc_vec[10]) begin w_code = 5'd1;  w_bad_en = 1'b1; w_tlb = 1'b1; end
        else if (eret)        begin w_eret = 1'b1; end
        else                  begin w_hit  = 1'b0; end
    end

    // Next state and next registered outputs; record pulses last one cycle, data fields hold
    always_comb begin
        w_state_nxt     = r_state;
        w_exp_en_nxt    = 1'b0;
        w_flush_nxt     = 1'b0;
        w_bad_en_nxt    = 1'b0;
        w_exl_clean_nxt = 1'b0;
        w_bd_nxt        = r_bd;
        w_code_nxt      = r_code;
        w_epc_nxt       = r_epc;
        w_badvaddr_nxt  = r_badvaddr;
        w_rvalid_nxt    = r_rvalid;
        w_rpc_nxt       = r_rpc;
        case (r_state)
            IDLE: begin
                if (commit_valid && w_hit) begin
                    w_state_nxt  = REDIRECT;
                    w_exp_en_nxt = 1'b1;
                    w_flush_nxt  = 1'b1;
                    w_rvalid_nxt = 1'b1;
                    if (w_eret) begin
                        w_exl_clean_nxt = 1'b1;
                        w_epc_nxt       = epc_address;
                        w_bd_nxt        = cp0_cause_bd;
                        w_code_nxt      = cp0_cause_exccode;
                        w_rpc_nxt       = epc_address;
                    end else begin
                        w_epc_nxt    = commit_bd ? (commit_pc - 32'd4) : commit_pc;
                        w_bd_nxt     = commit_bd;
                        w_code_nxt   = w_code;
                        w_bad_en_nxt = w_bad_en;
                        if (w_bad_en) w_badvaddr_nxt = w_bad;
                        w_rpc_nxt    = (w_tlb && tlb_refill) ? REFILL_VECTOR : EXC_VECTOR;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    w_state_nxt  = IDLE;
                    w_rvalid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_exp_en    <= 1'b0;
            r_flush     <= 1'b0;
            r_bad_en    <= 1'b0;
            r_exl_clean <= 1'b0;
            r_bd        <= 1'b0;
            r_code      <= 5'd0;
            r_epc       <= 32'd0;
            r_badvaddr  <= 32'd0;
            r_rvalid    <= 1'b0;
            r_rpc       <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_en    <= w_exp_en_nxt;
            r_flush     <= w_flush_nxt;
            r_bad_en    <= w_bad_en_nxt;
            r_exl_clean <= w_exl_clean_nxt;
            r_bd        <= w_bd_nxt;
            r_code      <= w_code_nxt;
            r_epc       <= w_epc_nxt;
            r_badvaddr  <= w_badvaddr_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rpc       <= w_rpc_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign exp_en          = r_exp_en;
    assign flush           = r_flush;
    assign exp_badvaddr_en = r_bad_en;
    assign exl_clean       = r_exl_clean;
    assign exp_bd          = r_bd;
    assign exp_code        = r_code;
    assign exp_epc         = r_epc;
    assign exp_badvaddr    = r_badvaddr;
    assign redirect_valid  = r_rvalid;
    assign redirect_pc     = r_rpc;
    assign busy            = r_busy;

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid, commit_bd, tlb_refill, eret, allow_interrupt, cp0_cause_bd, redirect_ready;
    logic [31:0] commit_pc, commit_mem_addr, epc_address;
    logic [11:0] exc_vec;
    logic [7:0]  interrupt_flag;
    logic [4:0]  cp0_cause_exccode;
    logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, flush, redirect_valid, busy;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc, exp_badvaddr, redirect_pc;

    int checks = 0;
    int errors = 0;

    exception_unit dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_bd(commit_bd), .commit_mem_addr(commit_mem_addr), .exc_vec(exc_vec),
        .tlb_refill(tlb_refill), .eret(eret), .allow_interrupt(allow_interrupt),
        .interrupt_flag(interrupt_flag), .epc_address(epc_address), .cp0_cause_bd(cp0_cause_bd),
        .cp0_cause_exccode(cp0_cause_exccode), .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en),
        .exp_bd(exp_bd), .exl_clean(exl_clean), .exp_code(exp_code), .exp_epc(exp_epc),
        .exp_badvaddr(exp_badvaddr), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // One retiring instruction; returns #1 after the sampling edge
    task automatic do_commit(input logic [31:0] pc, input logic bd, input logic [31:0] ma,
                             input logic [11:0] ev, input logic er);
        @(negedge clk);
        commit_valid = 1'b1; commit_pc = pc; commit_bd = bd; commit_mem_addr = ma;
        exc_vec = ev; eret = er;
        @(posedge clk); #1;
        commit_valid = 1'b0; exc_vec = 12'd0; eret = 1'b0;
    endtask

    task automatic do_ack;
        @(negedge clk); redirect_ready = 1'b1;
        @(posedge clk); #1; redirect_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        commit_valid = 0; commit_pc = 0; commit_bd = 0; commit_mem_addr = 0; exc_vec = 0;
        tlb_refill = 0; eret = 0; allow_interrupt = 0; interrupt_flag = 0; epc_address = 0;
        cp0_cause_bd = 0; cp0_cause_exccode = 0; redirect_ready = 0;
        repeat (2) @(posedge clk); #1;
        checks++; if ({exp_en, flush, redirect_valid, busy, exl_clean, exp_badvaddr_en} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000", {exp_en, flush, redirect_valid, busy, exl_clean, exp_badvaddr_en}); end
        checks++; if ({exp_epc, exp_badvaddr, redirect_pc, exp_code, exp_bd} !== 102'd0) begin
            errors++; $display("FAIL reset_data epc=%h bad=%h rpc=%h code=%0d", exp_epc, exp_badvaddr, redirect_pc, exp_code); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_sys;
        do_commit(32'h80001000, 1'b0, 32'h0, 12'h008, 1'b0);
        checks++; if ({exp_en, flush, redirect_valid, busy, exp_badvaddr_en, exl_clean} !== 6'b111100) begin
            errors++; $display("FAIL sys_ctrl got %b want 111100", {exp_en, flush, redirect_valid, busy, exp_badvaddr_en, exl_clean}); end
        checks++; if (exp_code !== 5'd8 || exp_epc !== 32'h80001000 || exp_bd !== 1'b0) begin
            errors++; $display("FAIL sys_rec code=%0d epc=%h bd=%b want 8 80001000 0", exp_code, exp_epc, exp_bd); end
        checks++; if (redirect_pc !== 32'hBFC00380) begin
            errors++; $display("FAIL sys_rpc got %h want bfc00380", redirect_pc); end
        @(posedge clk); #1;
        checks++; if ({exp_en, flush, redirect_valid, busy} !== 4'b0011) begin
            errors++; $display("FAIL sys_pulse got %b want 0011", {exp_en, flush, redirect_valid, busy}); end
        do_ack;
        checks++; if ({redirect_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL sys_ack got %b want 00", {redirect_valid, busy}); end
    endtask

    task automatic test_ades;
        do_commit(32'h80002004, 1'b1, 32'h00000003, 12'h080, 1'b0);
        checks++; if (exp_epc !== 32'h80002000 || exp_bd !== 1'b1 || exp_code !== 5'd5) begin
            errors++; $display("FAIL ades_rec epc=%h bd=%b code=%0d want 80002000 1 5", exp_epc, exp_bd, exp_code); end
        checks++; if (exp_badvaddr_en !== 1'b1 || exp_badvaddr !== 32'h3) begin
            errors++; $display("FAIL ades_bad en=%b addr=%h want 1 00000003", exp_badvaddr_en, exp_badvaddr); end
        do_ack;
    endtask

    task automatic test_tlbl;
        tlb_refill = 1'b1;
        do_commit(32'h80005000, 1'b0, 32'h00400000, 12'h100, 1'b0);
        checks++; if (exp_code !== 5'd2 || redirect_pc !== 32'hBFC00200 || exp_badvaddr !== 32'h00400000) begin
            errors++; $display("FAIL tlbl_refill code=%0d rpc=%h bad=%h want 2 bfc00200 00400000", exp_code, redirect_pc, exp_badvaddr); end
        do_ack;
        tlb_refill = 1'b0;
        do_commit(32'h80005000, 1'b0, 32'h00400000, 12'h100, 1'b0);
        checks++; if (exp_code !== 5'd2 || redirect_pc !== 32'hBFC00380) begin
            errors++; $display("FAIL tlbl_norefill code=%0d rpc=%h want 2 bfc00380", exp_code, redirect_pc); end
        do_ack;
    endtask

    task automatic test_int;
        allow_interrupt = 1'b1; interrupt_flag = 8'h04;
        do_commit(32'h80006000, 1'b0, 32'h0, 12'h004, 1'b0);
        allow_interrupt = 1'b0; interrupt_flag = 8'h00;
        checks++; if (exp_en !== 1'b1 || exp_code !== 5'd0 || exp_badvaddr_en !== 1'b0) begin
            errors++; $display("FAIL int_rec en=%b code=%0d bad_en=%b want 1 0 0", exp_en, exp_code, exp_badvaddr_en); end
        @(posedge clk); #1;
        checks++; if (exp_en !== 1'b0) begin
            errors++; $display("FAIL int_pulse got %b want 0", exp_en); end
        do_ack;
    endtask

    task automatic test_priority_wrap;
        do_commit(32'h00000000, 1'b1, 32'h00001234, 12'h041, 1'b0);
        checks++; if (exp_code !== 5'd4 || exp_badvaddr !== 32'h0 || exp_epc !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL ifadel_prio code=%0d bad=%h epc=%h want 4 00000000 fffffffc", exp_code, exp_badvaddr, exp_epc); end
        do_ack;
    endtask

    task automatic test_eret;
        epc_address = 32'h80003000; cp0_cause_exccode = 5'd8; cp0_cause_bd = 1'b0;
        do_commit(32'h80007000, 1'b0, 32'h0, 12'h000, 1'b1);
        epc_address = 32'h11111111;
        checks++; if (exp_en !== 1'b1 || exl_clean !== 1'b1 || exp_code !== 5'd8 || exp_epc !== 32'h80003000 || exp_badvaddr_en !== 1'b0) begin
            errors++; $display("FAIL eret_rec en=%b exl=%b code=%0d epc=%h bad_en=%b", exp_en, exl_clean, exp_code, exp_epc, exp_badvaddr_en); end
        checks++; if (redirect_pc !== 32'h80003000) begin
            errors++; $display("FAIL eret_rpc got %h want 80003000", redirect_pc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin commit_valid = 1'b1; exc_vec = 12'h008; end
            @(posedge clk); #1;
            commit_valid = 1'b0; exc_vec = 12'd0;
            checks++; if ({exp_en, flush, redirect_valid, busy} !== 4'b0011 || redirect_pc !== 32'h80003000) begin
                errors++; $display("FAIL eret_hold%0d ctrl=%b rpc=%h want 0011 80003000", i, {exp_en, flush, redirect_valid, busy}, redirect_pc); end
        end
        do_ack;
        checks++; if ({redirect_valid, busy, exp_en} !== 3'b000) begin
            errors++; $display("FAIL eret_ack got %b want 000", {redirect_valid, busy, exp_en}); end
    endtask

    task automatic test_back_to_back;
        do_commit(32'h80008000, 1'b0, 32'h0, 12'h010, 1'b0);
        do_ack;
        do_commit(32'h80008004, 1'b0, 32'h0, 12'h020, 1'b0);
        checks++; if (exp_en !== 1'b1 || exp_code !== 5'd12 || exp_epc !== 32'h80008004) begin
            errors++; $display("FAIL b2b_rec en=%b code=%0d epc=%h want 1 12 80008004", exp_en, exp_code, exp_epc); end
        do_ack;
    endtask

    task automatic test_reset_redirect;
        do_commit(32'h80009000, 1'b0, 32'h0, 12'h008, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        checks++; if ({redirect_valid, busy, redirect_pc} !== 34'd0) begin
            errors++; $display("FAIL rst_redirect valid=%b busy=%b rpc=%h want 0 0 0", redirect_valid, busy, redirect_pc); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_trap;
        do_commit(32'h8000A000, 1'b0, 32'h0, 12'h800, 1'b0);
`ifdef EXCEPTION_TRAP_EN
        checks++; if (exp_en !== 1'b1 || exp_code !== 5'd13 || exp_badvaddr_en !== 1'b0) begin
            errors++; $display("FAIL trap_rec en=%b code=%0d want 1 13", exp_en, exp_code); end
        do_ack;
`else
        checks++; if ({exp_en, busy, redirect_valid} !== 3'b000) begin
            errors++; $display("FAIL trap_ignored got %b want 000", {exp_en, busy, redirect_valid}); end
`endif
        do_commit(32'h8000A004, 1'b0, 32'h0, 12'h820, 1'b0);
`ifdef EXCEPTION_TRAP_EN
        checks++; if (exp_code !== 5'd13) begin
            errors++; $display("FAIL trap_over_ov got %0d want 13", exp_code); end
`else
        checks++; if (exp_code !== 5'd12) begin
            errors++; $display("FAIL ov_no_trap got %0d want 12", exp_code); end
`endif
        do_ack;
    endtask

    initial begin
        test_reset;
        test_sys;
        test_ades;
        test_tlbl;
        test_int;
        test_priority_wrap;
        test_eret;
        test_back_to_back;
        test_reset_redirect;
        test_trap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
Commit-stage exception arbiter directly upstream of the CP0 exception-update port.
- Samples the retiring instruction's exception flags, pending interrupts and ERET.
- Selects the highest-priority event and drives a one-cycle exp_en record into CP0.
- Flushes the pipeline and holds a redirect PC until fetch accepts it.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry
REFILL_VECTOR, 32'hBFC00200, TLB refill entry

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
commit_valid  in  1  instruction retiring this cycle
commit_pc  in  32  PC of retiring instruction
commit_bd  in  1  retiring instruction is in a delay slot
commit_mem_addr  in  32  data virtual address of retiring load/store
exc_vec  in  12  flags: 0 IF-AdEL, 1 IF-TLBL, 2 RI, 3 Sys, 4 Bp, 5 Ov, 6 AdEL, 7 AdES, 8 TLBL, 9 TLBS, 10 Mod, 11 Tr
tlb_refill  in  1  TLB fault is a refill (miss with EXL=0)
eret  in  1  retiring instruction is ERET
allow_interrupt  in  1  from CP0
interrupt_flag  in  8  from CP0 (IM & IP)
epc_address  in  32  current EPC from CP0
cp0_cause_bd  in  1  current Cause.BD
cp0_cause_exccode  in  5  current Cause.ExcCode
exp_en, exp_badvaddr_en, exp_bd, exl_clean  out  1 each  CP0 exception record
exp_code  out  5  ExcCode to CP0
exp_epc, exp_badvaddr  out  32 each  EPC / BadVAddr to CP0
flush  out  1  kill all younger pipeline stages
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  fetch target
redirect_ready  in  1  fetch accepts redirect
busy  out  1  unit not in IDLE; pipeline stalls commit

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE; reset mid-REDIRECT drops the request.
- Event when commit_valid and state IDLE: interrupt (allow_interrupt && |interrupt_flag), any exc_vec bit, or eret. commit_valid in REDIRECT is ignored.
- Priority high->low, ExcCode: Int 0; IF-AdEL 4; IF-TLBL 2; RI 10; Sys 8; Bp 9; Tr 13; Ov 12; AdEL 4; AdES 5; TLBL 2; TLBS 3; Mod 1; ERET lowest. Multiple bits set: only the highest is recorded.
- Latency: event sampled at edge N; exp_en and flush are registered, high for exactly one cycle after edge N; the CP0 update lands at edge N+1.
- Exception record:
  - exp_epc = commit_bd ? commit_pc-4 : commit_pc (32-bit wrap); exp_bd = commit_bd; exl_clean = 0.
  - exp_badvaddr_en = 1 for IF-AdEL/IF-TLBL (badvaddr = commit_pc) and AdEL/AdES/TLBL/TLBS/Mod (badvaddr = commit_mem_addr); 0 otherwise.
- ERET record: exp_en = 1, exl_clean = 1, exp_epc = epc_address, exp_bd = cp0_cause_bd, exp_code = cp0_cause_exccode, exp_badvaddr_en = 0; CP0 state is preserved except EXL cleared.
- Redirect target:
  - REFILL_VECTOR if the selected event is TLB-class and tlb_refill = 1; EXC_VECTOR otherwise.
  - ERET targets epc_address as sampled at edge N.
- FSM:
  - IDLE: on event -> REDIRECT; redirect_valid = 1 with registered redirect_pc from the cycle after edge N.
  - REDIRECT: hold redirect_valid and redirect_pc stable; on redirect_ready -> IDLE at that edge.
  - redirect_ready in the same cycle redirect_valid first rises is a legal one-cycle handshake.
- busy = (state != IDLE). flush never reasserts during REDIRECT.

Optional Feature:
EXCEPTION_TRAP_EN: defined -> exc_vec[11] raises Tr (ExcCode 13, no BadVAddr) at the listed priority. Undefined -> exc_vec[11] ignored entirely; no Tr logic synthesized.

Test Plan:
- Sys at commit_pc=0x80001000, bd=0 -> one-cycle exp_en, exp_code=8, exp_epc=0x80001000, badvaddr_en=0, redirect_pc=0xBFC00380.
- AdES at commit_pc=0x80002004 bd=1, mem_addr=0x00000003 -> exp_epc=0x80002000, exp_bd=1, exp_code=5, exp_badvaddr=0x3.
- TLBL with tlb_refill=1 -> exp_code=2, redirect_pc=0xBFC00200; same with tlb_refill=0 -> 0xBFC00380.
- interrupt_flag=0x04, allow_interrupt=1, exc_vec RI also set -> exp_code=0 (Int wins), single exp_en pulse.
- ERET with epc_address=0x80003000, cause_exccode=8 -> exl_clean=1, exp_code=8, redirect_pc=0x80003000; hold redirect_ready=0 for 3 cycles, redirect_valid/pc stable, second commit ignored.
- rst_n low during REDIRECT -> redirect_valid=0 immediately; Tr with macro undefined -> no exp_en.
